uart_tx: RTL
============

Name: uart_tx

Overview:
UART transmitter. Serialises one 8-bit byte per valid/ready handshake into the standard frame: start bit (0), 8 data bits LSB-first, stop bit (1). Drives the serial line that a synchronised, edge-detecting receiver on the far end samples. Sits between the bus-side TX staging logic and the pad; it generates its own bit timing from clk.

Parameters:
CLK_RATE, 100_000_000, clk frequency in Hz.
BAUD_RATE, 115200, line rate in bit/s.
CLKS_PER_BIT, CLK_RATE/BAUD_RATE (localparam, integer division), clk cycles per serial bit; must be >= 2 (elaboration-time assertion).

Ports:
clk     input   1  clock, rising edge.
nReset  input   1  asynchronous, active-low reset.
data    input   8  byte to send; sampled only on handshake.
valid   input   1  data is valid this cycle.
ready   output  1  block can accept a byte (state IDLE).
tx      output  1  serial line, idle high; registered.
busy    output  1  frame in progress (= ~ready).
done    output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset values (async on nReset low): tx=1, ready=1, busy=0, done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame aborts the frame; tx returns to 1 immediately; there is no partial-frame completion and no done pulse.
- Handshake: byte accepted at a rising edge where valid && ready. data is latched into the shift register at that edge. data/valid are ignored while ready=0.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1, ready=1. Handshake moves to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, each held for CLKS_PER_BIT cycles. Shift right; tx = shift[0]. Bit index 0..7; leave after bit 7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: tx falls in the first cycle after the handshake edge. A frame occupies exactly 10*CLKS_PER_BIT cycles from tx falling to re-entering IDLE.
- done: asserted for exactly one cycle, coincident with the first IDLE cycle (ready=1).
- Back-to-back: if valid is high in that IDLE cycle, the next handshake occurs there. The next start bit follows with no extra idle, so the minimum spacing is 10*CLKS_PER_BIT + 1 cycles between start-bit falling edges.
- Baud counter:
  - width $clog2(CLKS_PER_BIT).
  - Cleared on handshake.
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - Wrap is the bit boundary; state/bit-index advance only on wrap.
- Bit index: 3 bits; wraps 7->0 on the DATA->STOP transition.
- tx is driven from a flop; it carries no combinational path from data or valid.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 latched data bits), computed at handshake and held in a flop.
  - The bit lasts CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity flop; frame = 10*CLKS_PER_BIT cycles.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_WIDTH = 8.
  - The tx state enum (IDLE, START, DATA, PARITY, STOP); PARITY is present unconditionally in the enum.
  - A function computing CLKS_PER_BIT from CLK_RATE/BAUD_RATE, shared with the receiver.
- Sub-module uart_baud_gen (parameter CLKS_PER_BIT; inputs clk, nReset, clear; output tick) is the restartable baud counter, reusable by the receiver.

Test Plan (sim with CLK_RATE=40, BAUD_RATE=10 -> CLKS_PER_BIT=4):
1. Reset, then idle 20 cycles -> tx=1, ready=1, busy=0, done=0 throughout.
2. Send data=8'hA5 with a one-cycle valid -> tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. ready low for 40 cycles. done pulses once, on the cycle ready returns high.
3. Hold valid high with 8'h00 then 8'h FF back-to-back -> second start bit begins 41 cycles after the first; exactly two done pulses; tx never glitches high inside a frame of 8'h00.
4. Change data and toggle valid mid-frame -> transmitted byte unchanged; no extra handshake counted.
5. Deassert nReset during data bit 3 of 8'h3C -> tx=1 asynchronously, ready=1 after release, no done pulse. A following send of 8'h3C is framed correctly.
6. UART_TX_PARITY_EN defined, send 8'h07 -> parity bit 1 after data; frame 44 cycles. Send 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmitter state encoding and
// helpers reused by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_WIDTH = 8;

  // PARITY is always part of the encoding so both builds share one state type.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  function automatic int calc_clks_per_bit(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable baud counter: counts 0..CLKS_PER_BIT-1 and flags the last
// cycle of each bit period. A clear restarts the bit period from zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic nReset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear, wrap at the bit boundary, else increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_RATE  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_RATE, BAUD_RATE);

  if (CLKS_PER_BIT < 2) begin : g_rate_check
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  tx_state_e             state_q;
  tx_state_e             state_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [2:0]            bit_idx_q;
  logic [2:0]            bit_idx_d;
  logic                  tx_q;
  logic                  tx_d;
  logic                  done_q;
  logic                  done_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
  logic                  parity_d;
`endif

  logic ready_s;
  logic handshake_s;
  logic tick_s;

  assign ready_s     = (state_q == IDLE);
  assign handshake_s = valid && ready_s;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk   (clk),
    .nReset(nReset),
    .clear (handshake_s),
    .tick  (tick_s)
  );

  // Frame sequencing; tx_d is the line level for the state being entered,
  // so the registered tx changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (handshake_s) begin
          state_d = START;
          shift_d = data;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(data);
`endif
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      START: begin
        if (tick_s) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            state_d = DATA;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick_s) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_idx_d = 3'd0;
        tx_d      = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      shift_q   <= {DATA_WIDTH{1'b0}};
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign ready = ready_s;
  assign busy  = ~ready_s;
  assign tx    = tx_q;
  assign done  = done_q;

endmodule
